uart_ctrl: RTL and testbench
============================

# uart_ctrl

Bus-side controller that sequences the memory-mapped UART on behalf of several byte producers and buffers received bytes. It owns the UART register port (address, write data, write enable, read data) and arbitrates transmit requests round-robin. It issues each byte, waits for the transmitter to report idle, and clears the receive flag. Received bytes are captured from the UART's `rxnew`/`rxdata` pulse outputs into a small FIFO. It sits between the requesters (CPU console path, debug/boot loaders) and a single UART instance.

## Interface
- `NREQ`, 4: number of transmit requesters, range 1..8.
- `RX_DEPTH`, 4: RX FIFO depth; must be a power of 2, at least 2.
- `TIMEOUT_CYCLES`, 65535: poll limit in clock cycles; used only with the timeout macro; maximum 65535.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req` in NREQ: per-requester transmit request; held until `ack`.
- `req_data` in 8*NREQ: byte for requester i at bits [8i+7:8i]; stable while `req[i]` is high.
- `ack` out NREQ: one-cycle pulse when that requester's byte is written to the UART.
- `tx_busy` out 1: high in any state other than IDLE.
- `rx_valid` out 1: RX FIFO non-empty.
- `rx_byte` out 8: FIFO head byte; 0 when empty.
- `rx_pop` in 1: dequeue head; ignored when empty.
- `rx_overflow` out 1: sticky flag; a byte was dropped.
- `ovf_clr` in 1: clears `rx_overflow`.
- `tx_timeout` out 1: sticky flag; a poll timed out. Cleared by `ovf_clr`.
- `uart_a` out 3: UART register address.
- `uart_d` out 32: UART write data; the byte is carried in [31:24].
- `uart_we` out 1: UART write enable.
- `uart_spo` in 32: UART read data; the status bit is [24].
- `uart_rxnew` in 1: one-cycle pulse, new byte received.
- `uart_rxdata` in 8: received byte; valid with `uart_rxnew`.

## Operation
- FSM states: IDLE, ISSUE, SETTLE, POLL, CLR.
- IDLE:
  - If `clr_pend` is set, go to CLR. CLR has priority over transmit.
  - Otherwise, if any `req` is high, register the winner and its byte, then go to ISSUE.
- Round-robin arbitration: the search starts at `last_grant+1` modulo NREQ. `last_grant` updates in ISSUE. Its reset value is NREQ-1, so requester 0 wins first.
- ISSUE, 1 cycle: `uart_we`=1, `uart_a`=0, `uart_d`={byte,24'b0}, `ack[winner]`=1. Next state is SETTLE.
- SETTLE, 1 cycle: `uart_a`=2, no write. Next state is POLL. This absorbs the UART's IDLE→START transition.
- POLL: `uart_a`=2. Stays until `uart_spo[24]`=1, then goes to IDLE.
- CLR, 1 cycle: `uart_we`=1, `uart_a`=1, `uart_d`=0. Clears `clr_pend`, then goes to IDLE.
- `clr_pend` is set on every `uart_rxnew` pulse. If a set and a clear happen in the same cycle, the set wins.
- Outside ISSUE and CLR: `uart_we`=0 and `uart_d`=0. `uart_a`=0 in IDLE.
- RX FIFO push:
  - On `uart_rxnew`, push `uart_rxdata`. This is independent of FSM state.
  - When the FIFO is full and there is no pop in the same cycle, drop the new byte and set `rx_overflow`.
  - Full FIFO with push and pop in the same cycle: both happen, no overflow.
- RX FIFO pointers are log2(RX_DEPTH)+1 bits wide and wrap naturally. Full means the MSBs differ and the low bits are equal.
- `ovf_clr` clears both sticky flags. If a set and `ovf_clr` occur in the same cycle, the set wins.

## Timing
- Reset (async assert, sync deassert expected):
  - State is IDLE.
  - All outputs are 0: `ack`, `tx_busy`, `rx_valid`, `rx_byte`, `rx_overflow`, `tx_timeout`, `uart_a`, `uart_d`, `uart_we`.
  - FIFO is empty and `clr_pend` is 0.
  - Reset mid-transaction abandons the transaction with no `ack`.
- Latency: `req` sampled high in IDLE at edge N gives ISSUE (with `ack` and `uart_we`) in cycle N+1.
- Minimum transmit cycle is ISSUE+SETTLE+POLL(1)+IDLE = 4 cycles.
- Two simultaneous requesters are acked in round-robin order. No requester waits more than NREQ transactions.
- RX: a `uart_rxnew` pulse in cycle N sets `rx_valid` at N+1 if the FIFO was empty.
- `rx_pop` takes effect at the clock edge. The new head appears the next cycle.

## Configuration
- `UART_CTRL_TIMEOUT_EN` defined:
  - A 16-bit counter runs in POLL. It reaches TIMEOUT_CYCLES when the POLL cycle count equals TIMEOUT_CYCLES.
  - When it does, the FSM goes to IDLE and sets `tx_timeout`.
  - The byte counts as acked; it is not retried.
- Not defined: POLL waits indefinitely, and `tx_timeout` is constant 0.

## Test plan
- Single send:
  - Stimulus: `req`=0001 with `req_data[7:0]`=8'h41; model `uart_spo[24]`=0 for 10 cycles, then 1.
  - Required: `ack`=0001 for one cycle; `uart_we`=1, `uart_a`=0, `uart_d`=32'h41000000 in that cycle; POLL holds 10 cycles, then IDLE.
- Fairness: `req`=1111 held continuously. Acks in order 0,1,2,3,0, each byte written exactly once.
- RX capture:
  - Stimulus: `uart_rxnew` pulses carrying 8'h55 and then 8'hAA, while a transmit is in POLL.
  - Required: the FIFO holds 55 then AA; CLR (`uart_we`=1, `uart_a`=1) occurs once after POLL exits, before the next ISSUE.
- Overflow:
  - Stimulus: push 5 bytes with RX_DEPTH=4 and no pop.
  - Required: first 4 retained, 5th dropped, `rx_overflow`=1; `ovf_clr` returns it to 0.
- Full plus pop: with the FIFO full, `uart_rxnew` and `rx_pop` in the same cycle. Head advances, new byte at tail, `rx_overflow` stays 0.
- Timeout (macro on, TIMEOUT_CYCLES=16): `uart_spo[24]` stuck at 0. IDLE after 16 POLL cycles and `tx_timeout`=1; `rst_n` low mid-POLL clears all outputs immediately.

Source files
------------

// File: rtl/uart_ctrl.sv
// uart_ctrl: sequences a memory-mapped UART for NREQ byte producers.
// Transmit requests are arbitrated round-robin; each byte is written, then the
// transmitter status is polled until idle. Received bytes are captured into a
// small FIFO and the UART receive flag is cleared from the controller FSM.
// Optional feature macro: UART_CTRL_TIMEOUT_EN (bounded POLL with tx_timeout).
module uart_ctrl #(
  parameter int NREQ           = 4,
  parameter int RX_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     ack,
  output logic                tx_busy,
  output logic                rx_valid,
  output logic [7:0]          rx_byte,
  input  logic                rx_pop,
  output logic                rx_overflow,
  input  logic                ovf_clr,
  output logic                tx_timeout,
  output logic [2:0]          uart_a,
  output logic [31:0]         uart_d,
  output logic                uart_we,
  input  logic [31:0]         uart_spo,
  input  logic                uart_rxnew,
  input  logic [7:0]          uart_rxdata
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW = $clog2(RX_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_POLL   = 3'd3;
  localparam logic [2:0] S_CLR    = 3'd4;

  logic [2:0]    state, state_nxt;
  logic [GW-1:0] winner, last_grant, pick;
  logic          pick_vld;
  logic          grant;
  logic [7:0]    tx_byte;
  logic          clr_pend;
  logic          timeout_hit;

  // Only the transmitter-idle bit of the status word is meaningful here.
  logic [30:0]   unused_spo;
  assign unused_spo = {uart_spo[31:25], uart_spo[23:0]};

  // Round-robin search starting just after the last granted requester.
  always_comb begin : arb_search
    int idx;
    idx      = 0;
    pick     = last_grant;
    pick_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!pick_vld && req[idx]) begin
        pick     = GW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // A transmit is only accepted from IDLE when no receive-flag clear is owed.
  assign grant = (state == S_IDLE) && !clr_pend && pick_vld;

  // Next-state logic; a pending receive-flag clear outranks transmit.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (clr_pend)      state_nxt = S_CLR;
        else if (pick_vld) state_nxt = S_ISSUE;
      end
      S_ISSUE:  state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_POLL;
      S_POLL:   if (uart_spo[24] || timeout_hit) state_nxt = S_IDLE;
      S_CLR:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Control state: FSM, granted requester, arbitration pointer, clear-pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      winner     <= '0;
      last_grant <= GW'(NREQ - 1);
      clr_pend   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) winner <= pick;
      if (state == S_ISSUE) last_grant <= winner;
      // A new receive pulse re-arms the clear even in the CLR cycle itself.
      clr_pend <= uart_rxnew | (clr_pend & (state != S_CLR));
    end
  end

  // Latch the winning byte; data path only, so no reset.
  always_ff @(posedge clk) begin
    if (grant) tx_byte <= req_data[int'(pick)*8 +: 8];
  end

  // UART register port and acknowledge decode from the current state.
  always_comb begin
    ack     = '0;
    uart_we = 1'b0;
    uart_a  = 3'd0;
    uart_d  = 32'h0;
    case (state)
      S_ISSUE: begin
        uart_we = 1'b1;
        uart_d  = {tx_byte, 24'h0};
        ack     = NREQ'(1) << winner;
      end
      S_SETTLE, S_POLL: uart_a = 3'd2;
      S_CLR: begin
        uart_we = 1'b1;
        uart_a  = 3'd1;
      end
      default: ;
    endcase
  end

  assign tx_busy = (state != S_IDLE);

`ifdef UART_CTRL_TIMEOUT_EN
  logic [15:0] poll_cnt;

  assign timeout_hit = (state == S_POLL) && (poll_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Count POLL cycles and raise the sticky timeout flag when the limit expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_cnt   <= 16'h0;
      tx_timeout <= 1'b0;
    end else begin
      if (state == S_POLL) poll_cnt <= poll_cnt + 16'd1;
      else                 poll_cnt <= 16'h0;
      if (timeout_hit && !uart_spo[24]) tx_timeout <= 1'b1;
      else if (ovf_clr)                 tx_timeout <= 1'b0;
    end
  end
`else
  logic [15:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 16'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
  assign tx_timeout         = 1'b0;
`endif

  // RX FIFO: extra pointer MSB distinguishes full from empty.
  logic [7:0]    rx_mem [RX_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full, do_pop, do_push;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop     = rx_pop && !fifo_empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign do_push    = uart_rxnew && (!fifo_full || do_pop);

  // FIFO pointers and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (uart_rxnew && !do_push) rx_overflow <= 1'b1;
      else if (ovf_clr)           rx_overflow <= 1'b0;
    end
  end

  // FIFO storage write; data only, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) rx_mem[wr_ptr[AW-1:0]] <= uart_rxdata;
  end

  assign rx_valid = !fifo_empty;
  assign rx_byte  = fifo_empty ? 8'h00 : rx_mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: directed FIFO vector table, hand-written
// transmit / receive / reset sequences, and a randomized run against a
// transaction-level reference model (queue FIFO, round-robin search).
module tb_uart_ctrl;
  localparam int NREQ = 4;
  localparam int RX_DEPTH = 4;
  localparam int TOC = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic              tx_busy, rx_valid, rx_overflow, tx_timeout, uart_we;
  logic [7:0]        rx_byte, uart_rxdata;
  logic              rx_pop, ovf_clr, uart_rxnew;
  logic [2:0]        uart_a;
  logic [31:0]       uart_d, uart_spo;

  int errors = 0;
  int checks = 0;

  uart_ctrl #(.NREQ(NREQ), .RX_DEPTH(RX_DEPTH), .TIMEOUT_CYCLES(TOC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .tx_busy(tx_busy), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_pop(rx_pop),
    .rx_overflow(rx_overflow), .ovf_clr(ovf_clr), .tx_timeout(tx_timeout),
    .uart_a(uart_a), .uart_d(uart_d), .uart_we(uart_we), .uart_spo(uart_spo),
    .uart_rxnew(uart_rxnew), .uart_rxdata(uart_rxdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rxnew;
    logic [7:0] rxdata;
    logic       pop;
    logic       clr;
    logic       exp_vld;
    logic [7:0] exp_byte;
    logic       exp_ovf;
  } vec_t;

  vec_t vt[21];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Status word with random don't-care bits and the idle bit forced.
  function automatic logic [31:0] spo_word(input logic idle);
    logic [31:0] w;
    w = $urandom;
    w[24] = idle;
    return w;
  endfunction

  task automatic reset_dut();
    rst_n = 1'b0;
    req = '0; req_data = '0; rx_pop = 1'b0; ovf_clr = 1'b0;
    uart_rxnew = 1'b0; uart_rxdata = 8'h00; uart_spo = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " ack"}, ack, 0);
    chk({nm, " tx_busy"}, tx_busy, 0);
    chk({nm, " rx_valid"}, rx_valid, 0);
    chk({nm, " rx_byte"}, rx_byte, 0);
    chk({nm, " rx_overflow"}, rx_overflow, 0);
    chk({nm, " tx_timeout"}, tx_timeout, 0);
    chk({nm, " uart_a"}, uart_a, 0);
    chk({nm, " uart_d"}, uart_d, 0);
    chk({nm, " uart_we"}, uart_we, 0);
  endtask

  // Wait (bounded) for the next ack and compare it.
  task automatic wait_ack(input string nm, input logic [NREQ-1:0] exp);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (ack == '0 && n < 12);
    chk(nm, ack, exp);
  endtask

  // Reference-model state for the randomized run.
  logic [7:0]        mq[$];
  logic              m_ovf, pend_cur, prev_is_clr, is_issue, is_clr, popped, ovf_set;
  logic [NREQ-1:0]   prev_req, exp_ack;
  logic [8*NREQ-1:0] prev_data;
  logic              prev_rxnew, prev_pop, prev_clr;
  logic [7:0]        prev_rxdata;
  int                last_ack, exp_w, n;

  initial begin
    // Reset state
    rst_n = 1'b0;
    req = '0; req_data = '0; rx_pop = 1'b0; ovf_clr = 1'b0;
    uart_rxnew = 1'b0; uart_rxdata = 8'h00; uart_spo = 32'h0;
    tick();
    chk_all_zero("reset");
    #1 rst_n = 1'b1;

    // FIFO vector table: push/pop/overflow/clear, one row per clock
    vt[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
    vt[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
    vt[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
    vt[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
    vt[4]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
    vt[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0};
    vt[6]  = '{1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0};
    vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0};
    vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0};
    vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h66, 1'b0};
    vt[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vt[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vt[12] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0};
    vt[13] = '{1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0};
    vt[14] = '{1'b1, 8'h82, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0};
    vt[15] = '{1'b1, 8'h83, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0};
    vt[16] = '{1'b1, 8'h84, 1'b0, 1'b1, 1'b1, 8'h77, 1'b1};
    vt[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h81, 1'b0};
    vt[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h82, 1'b0};
    vt[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h83, 1'b0};
    vt[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    for (int i = 0; i < 21; i++) begin
      uart_rxnew = vt[i].rxnew; uart_rxdata = vt[i].rxdata;
      rx_pop = vt[i].pop; ovf_clr = vt[i].clr;
      tick();
      chk($sformatf("vec%0d rx_valid", i), rx_valid, vt[i].exp_vld);
      chk($sformatf("vec%0d rx_byte", i), rx_byte, vt[i].exp_byte);
      chk($sformatf("vec%0d rx_overflow", i), rx_overflow, vt[i].exp_ovf);
    end

    // Single send: 10 polls with status 0, then status 1
    reset_dut();
    req = 4'b0001; req_data[7:0] = 8'h41; uart_spo = spo_word(1'b0);
    tick();
    chk("send ack", ack, 4'b0001);
    chk("send we", uart_we, 1);
    chk("send a", uart_a, 0);
    chk("send d", uart_d, 32'h4100_0000);
    req = '0;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c <= 12) begin
        chk($sformatf("send busy c%0d", c), tx_busy, 1);
        chk($sformatf("send a c%0d", c), uart_a, 2);
        chk($sformatf("send we c%0d", c), {uart_we, ack}, 0);
      end else begin
        chk("send idle after poll", tx_busy, 0);
        chk("send idle a", uart_a, 0);
      end
      uart_spo = spo_word(c == 12);
    end

    // Fairness: all four held, acks 0,1,2,3,0
    reset_dut();
    req = 4'b1111; req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; uart_spo = spo_word(1'b1);
    for (int k = 0; k < 5; k++) begin
      wait_ack($sformatf("fair ack%0d", k), NREQ'(1) << (k % NREQ));
      chk($sformatf("fair d%0d", k), uart_d, {8'(8'hA0 + k % NREQ), 24'h0});
    end
    req = '0;

    // RX capture during POLL, then one CLR before the next ISSUE
    reset_dut();
    req = 4'b0001; req_data = {8'h00, 8'h00, 8'h77, 8'h5A}; uart_spo = spo_word(1'b0);
    tick();                                     // c0 ISSUE
    chk("rxcap ack0", ack, 4'b0001);
    req = 4'b0010;
    tick(); tick(); tick();                     // c3 POLL
    uart_rxnew = 1'b1; uart_rxdata = 8'h55;
    tick();                                     // c4
    uart_rxnew = 1'b0;
    chk("rxcap valid", rx_valid, 1);
    chk("rxcap head55", rx_byte, 8'h55);
    tick();                                     // c5
    uart_rxnew = 1'b1; uart_rxdata = 8'hAA;
    tick();                                     // c6
    uart_rxnew = 1'b0;
    chk("rxcap still polling", {tx_busy, uart_a}, {1'b1, 3'd2});
    tick();                                     // c7
    uart_spo = spo_word(1'b1);
    tick();                                     // c8 IDLE
    chk("rxcap idle", tx_busy, 0);
    tick();                                     // c9 CLR
    chk("rxcap clr", {uart_we, uart_a, uart_d, ack}, {1'b1, 3'd1, 32'h0, 4'b0});
    tick();                                     // c10 IDLE
    chk("rxcap single clr", {uart_we, tx_busy}, 0);
    tick();                                     // c11 ISSUE
    chk("rxcap ack1", ack, 4'b0010);
    chk("rxcap d1", uart_d, 32'h7700_0000);
    req = '0;
    chk("rxcap head still 55", rx_byte, 8'h55);
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
    chk("rxcap head AA", rx_byte, 8'hAA);

    // Stuck status: timeout (when built in) and reset mid-POLL
    reset_dut();
    req = 4'b0001; req_data[7:0] = 8'h33; uart_spo = spo_word(1'b0);
    uart_rxnew = 1'b1; uart_rxdata = 8'h99;
    tick();
    uart_rxnew = 1'b0;
    chk("stuck ack", ack, 4'b0001);
    req = '0;
`ifdef UART_CTRL_TIMEOUT_EN
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (!tx_busy) break;
      n++;
    end
    chk("timeout settle+poll cycles", n, TOC + 1);
    chk("timeout flag", tx_timeout, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("timeout cleared", tx_timeout, 0);
    repeat (3) tick();                          // let the pending CLR finish
    req = 4'b0001;
    wait_ack("stuck ack2", 4'b0001);
    req = '0;
    repeat (4) tick();
`else
    repeat (40) tick();
    chk("stuck still polling", {tx_busy, uart_a}, {1'b1, 3'd2});
    chk("stuck no timeout", tx_timeout, 0);
`endif
    chk("stuck fifo holds byte", rx_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("mid-poll reset");
    tick();
    chk("reset no ack", ack, 0);
    #1 rst_n = 1'b1;

    // Randomized run against the reference model
    reset_dut();
    mq.delete();
    m_ovf = 1'b0; pend_cur = 1'b0; prev_is_clr = 1'b0; last_ack = NREQ - 1;
    prev_req = '0; prev_data = '0; prev_rxnew = 1'b0; prev_pop = 1'b0;
    prev_clr = 1'b0; prev_rxdata = 8'h00;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      popped = prev_pop && (mq.size() > 0);
      if (popped) void'(mq.pop_front());
      ovf_set = 1'b0;
      if (prev_rxnew) begin
        if (mq.size() < RX_DEPTH) mq.push_back(prev_rxdata);
        else ovf_set = 1'b1;
      end
      m_ovf = ovf_set | (m_ovf & ~prev_clr);
      chk("rand rx_valid", rx_valid, mq.size() > 0);
      chk("rand rx_byte", rx_byte, (mq.size() > 0) ? mq[0] : 8'h00);
      chk("rand rx_overflow", rx_overflow, m_ovf);
`ifndef UART_CTRL_TIMEOUT_EN
      chk("rand tx_timeout", tx_timeout, 0);
`endif
      is_issue = uart_we && (uart_a == 3'd0);
      is_clr = uart_we && (uart_a == 3'd1);
      if (is_issue) begin
        exp_w = -1;
        for (int k = 1; k <= NREQ; k++)
          if (exp_w < 0 && prev_req[(last_ack + k) % NREQ]) exp_w = (last_ack + k) % NREQ;
        exp_ack = (exp_w < 0) ? '0 : NREQ'(1) << exp_w;
        chk("rand ack", ack, exp_ack);
        if (exp_w >= 0) begin
          chk("rand uart_d", uart_d, {prev_data[8*exp_w +: 8], 24'h0});
          last_ack = exp_w;
        end
        chk("rand issue with clear pending", pend_cur, 0);
      end else begin
        chk("rand ack quiet", ack, 0);
      end
      if (is_clr) begin
        chk("rand clr without rx", pend_cur, 1);
        chk("rand clr data", uart_d, 0);
      end
      if (!uart_we) chk("rand d quiet", uart_d, 0);
      pend_cur = prev_rxnew | (pend_cur & ~prev_is_clr);
      prev_is_clr = is_clr;
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(3) == 0) begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end
      end
      uart_rxnew = ($urandom_range(3) == 0);
      uart_rxdata = 8'($urandom);
      rx_pop = ($urandom_range(2) == 0);
      ovf_clr = ($urandom_range(15) == 0);
      uart_spo = spo_word($urandom_range(2) == 0);
      prev_req = req; prev_data = req_data; prev_rxnew = uart_rxnew;
      prev_rxdata = uart_rxdata; prev_pop = rx_pop; prev_clr = ovf_clr;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
